// File: rtl/fir_bram_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fir_bram_seq
//  Description : Sequencer/arbiter for the FIR tap RAM and data RAM.
//                Clears the data RAM on start, accepts one sample at a time
//                into a circular buffer, then issues TAPS paired reads per
//                sample to feed the MAC. The host shares the tap RAM and is
//                served only while the sequencer is idle.
//  Ports       : clk/rst            - clock, synchronous active-high reset
//                start/data_len     - run request and samples per run
//                s_valid/s_data/s_ready - sample input handshake
//                host_*             - tap configuration port (req held to ack)
//                tap_* / dat_*      - tap RAM / data RAM strobes, addresses, data
//                mac_*              - operands and first/last flags for the MAC
//                busy/done          - run status
//                stall_cnt          - WAIT_IN starvation counter
//  Options     : FIR_SEQ_STALL_CNT_EN - build the stall counter
//                (otherwise stall_cnt is tied to 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_bram_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int TAPS       = 11,
    parameter int BIT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           data_len,
    input  logic                  s_valid,
    input  logic [BIT_WIDTH-1:0]  s_data,
    output logic                  s_ready,
    input  logic                  host_we,
    input  logic                  host_re,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [BIT_WIDTH-1:0]  host_wdata,
    output logic [BIT_WIDTH-1:0]  host_rdata,
    output logic                  host_ack,
    output logic                  tap_we,
    output logic                  tap_re,
    output logic [ADDR_WIDTH-1:0] tap_waddr,
    output logic [ADDR_WIDTH-1:0] tap_raddr,
    output logic [BIT_WIDTH-1:0]  tap_wdi,
    input  logic [BIT_WIDTH-1:0]  tap_rdo,
    output logic                  dat_we,
    output logic                  dat_re,
    output logic [ADDR_WIDTH-1:0] dat_waddr,
    output logic [ADDR_WIDTH-1:0] dat_raddr,
    output logic [BIT_WIDTH-1:0]  dat_wdi,
    input  logic [BIT_WIDTH-1:0]  dat_rdo,
    output logic                  mac_valid,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic [BIT_WIDTH-1:0]  mac_x,
    output logic [BIT_WIDTH-1:0]  mac_h,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_WAIT_IN = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_TAPS_A = ADDR_WIDTH'(TAPS);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_A = ADDR_WIDTH'(TAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE_A  = ADDR_WIDTH'(1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [31:0]           r_len;
    logic [31:0]           r_count;
    logic                  r_rd_pend;
    logic                  r_rd_oob;
    logic                  r_mac_valid;
    logic                  r_mac_first;
    logic                  r_mac_last;

    // Host is served only in IDLE, loses to start, and a read in flight
    // blocks a new request while the host still holds its strobe.
    logic                  w_host_ok;
    logic                  w_host_wr;
    logic                  w_host_rd;
    logic                  w_host_inrange;
    logic                  w_rd_done;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [31:0]           w_count_next;

    assign w_host_ok      = !rst && (r_state == S_IDLE) && !start && !r_rd_pend;
    assign w_host_wr      = w_host_ok && host_we;
    assign w_host_rd      = w_host_ok && !host_we && host_re;
    assign w_host_inrange = (host_addr < c_TAPS_A);
    assign w_rd_done      = !rst && r_rd_pend;
    // Newest sample sits at wptr; tap k pairs with the sample k steps older.
    assign w_rd_addr      = (r_wptr >= r_k) ? (r_wptr - r_k) : (r_wptr + c_TAPS_A - r_k);
    assign w_count_next   = r_count + 32'd1;

    assign s_ready    = !rst && (r_state == S_WAIT_IN);
    assign busy       = (r_state != S_IDLE);
    assign done       = !rst && (r_state == S_DONE);
    assign host_ack   = w_host_wr || w_rd_done;
    assign host_rdata = (w_rd_done && !r_rd_oob) ? tap_rdo : '0;
    assign mac_valid  = r_mac_valid;
    assign mac_first  = r_mac_first;
    assign mac_last   = r_mac_last;
    assign mac_x      = r_mac_valid ? dat_rdo : '0;
    assign mac_h      = r_mac_valid ? tap_rdo : '0;

    always_comb begin
        tap_we    = 1'b0;
        tap_re    = 1'b0;
        tap_waddr = '0;
        tap_raddr = '0;
        tap_wdi   = '0;
        dat_we    = 1'b0;
        dat_re    = 1'b0;
        dat_waddr = '0;
        dat_raddr = '0;
        dat_wdi   = '0;
        // Out-of-range host accesses are acked without touching the RAM.
        if (w_host_wr && w_host_inrange) begin
            tap_we    = 1'b1;
            tap_waddr = host_addr;
            tap_wdi   = host_wdata;
        end
        if (w_host_rd && w_host_inrange) begin
            tap_re    = 1'b1;
            tap_raddr = host_addr;
        end
        if (!rst) begin
            case (r_state)
                S_CLEAR: begin
                    dat_we    = 1'b1;
                    dat_waddr = r_k;
                end
                S_WAIT_IN: begin
                    if (s_valid) begin
                        dat_we    = 1'b1;
                        dat_waddr = r_wptr;
                        dat_wdi   = s_data;
                    end
                end
                S_ISSUE: begin
                    tap_re    = 1'b1;
                    tap_raddr = r_k;
                    dat_re    = 1'b1;
                    dat_raddr = w_rd_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_wptr      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_oob    <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
        end else begin
            r_rd_pend   <= w_host_rd;
            r_rd_oob    <= !w_host_inrange;
            // Issue-cycle flags delayed one cycle to line up with RAM data.
            r_mac_valid <= (r_state == S_ISSUE);
            r_mac_first <= (r_state == S_ISSUE) && (r_k == '0);
            r_mac_last  <= (r_state == S_ISSUE) && (r_k == c_LAST_A);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= data_len;
                        r_count <= '0;
                        r_wptr  <= '0;
                        r_k     <= '0;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_k == c_LAST_A) begin
                        r_k     <= '0;
                        r_state <= (r_len == 32'd0) ? S_DONE : S_WAIT_IN;
                    end else begin
                        r_k <= r_k + c_ONE_A;
                    end
                end
                S_WAIT_IN: begin
                    if (s_valid) begin
                        r_k     <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_k == c_LAST_A) begin
                        r_k     <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + c_ONE_A;
                    end
                end
                S_DRAIN: begin
                    r_wptr  <= (r_wptr == c_LAST_A) ? '0 : (r_wptr + c_ONE_A);
                    r_count <= w_count_next;
                    r_state <= (w_count_next == r_len) ? S_DONE : S_WAIT_IN;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIR_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_WAIT_IN) && !s_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_bram_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_bram_seq
//  Description : Self-checking bench for fir_bram_seq. Models both RAMs with
//                1-cycle read latency, drives a host-op table, directed runs
//                and randomised runs, and predicts MAC operands from the
//                sample history and tap values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_bram_seq;

    localparam int AW = 12;
    localparam int NT = 11;
    localparam int BW = 32;
    localparam logic [AW-1:0] NT_A = AW'(NT);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   data_len;
    logic          s_valid;
    logic [BW-1:0] s_data;
    logic          s_ready;
    logic          host_we, host_re;
    logic [AW-1:0] host_addr;
    logic [BW-1:0] host_wdata, host_rdata;
    logic          host_ack;
    logic          tap_we, tap_re, dat_we, dat_re;
    logic [AW-1:0] tap_waddr, tap_raddr, dat_waddr, dat_raddr;
    logic [BW-1:0] tap_wdi, dat_wdi;
    logic [BW-1:0] tap_rdo = '0;
    logic [BW-1:0] dat_rdo = '0;
    logic          mac_valid, mac_first, mac_last;
    logic [BW-1:0] mac_x, mac_h;
    logic          busy, done;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    fir_bram_seq #(.ADDR_WIDTH(AW), .TAPS(NT), .BIT_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .data_len(data_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .tap_we(tap_we), .tap_re(tap_re), .tap_waddr(tap_waddr), .tap_raddr(tap_raddr),
        .tap_wdi(tap_wdi), .tap_rdo(tap_rdo),
        .dat_we(dat_we), .dat_re(dat_re), .dat_waddr(dat_waddr), .dat_raddr(dat_raddr),
        .dat_wdi(dat_wdi), .dat_rdo(dat_rdo),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .mac_x(mac_x), .mac_h(mac_h), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    // Block RAM models: write-first not needed, reads registered.
    logic [BW-1:0] tap_mem [NT];
    logic [BW-1:0] dat_mem [NT];

    always @(posedge clk) begin
        if (tap_we && tap_waddr < NT_A) tap_mem[tap_waddr[3:0]] <= tap_wdi;
        if (tap_re) tap_rdo <= (tap_raddr < NT_A) ? tap_mem[tap_raddr[3:0]] : '0;
        if (dat_we && dat_waddr < NT_A) dat_mem[dat_waddr[3:0]] <= dat_wdi;
        if (dat_re) dat_rdo <= (dat_raddr < NT_A) ? dat_mem[dat_raddr[3:0]] : '0;
    end

    int errors = 0;
    int checks = 0;
    int exp_stall;
    logic [BW-1:0] tap_model [NT];
    logic [BW-1:0] samp [$];

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] exp_rdata;
        bit            exp_strobe;
    } host_vec_t;

    host_vec_t hv [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic host_op(input host_vec_t v);
        host_addr  = v.addr;
        host_wdata = v.wdata;
        host_we    = v.is_wr;
        host_re    = !v.is_wr;
        @(negedge clk);
        if (v.is_wr) begin
            chk("host_wr_ack", host_ack, 1'b1);
            chk("host_wr_strobe", tap_we, v.exp_strobe);
            if (v.exp_strobe) begin
                chk("host_wr_addr_data", {tap_waddr, tap_wdi}, {v.addr, v.wdata});
                tap_model[v.addr[3:0]] = v.wdata;
            end
        end else begin
            chk("host_rd_strobe", {tap_re, tap_raddr}, {v.exp_strobe, v.exp_strobe ? v.addr : AW'(0)});
            chk("host_rd_early_ack", host_ack, 1'b0);
            step();
            @(negedge clk);
            chk("host_rd_ack", host_ack, 1'b1);
            chk("host_rd_data", host_rdata, v.exp_rdata);
        end
        step();
        host_we = 1'b0;
        host_re = 1'b0;
    endtask

    // One complete run over samp[0..len-1]; optionally holds a host write
    // pending for the whole run.
    task automatic run(input int len, input bit hold);
        logic [BW-1:0] hist [$];
        logic [BW-1:0] exp_x;
        int d;
        int k;
        exp_stall = 0;
        data_len  = len;
        start     = 1'b1;
        if (hold) begin
            host_we    = 1'b1;
            host_addr  = AW'(2);
            host_wdata = 32'h0BAD_0002;
        end
        @(negedge clk);
        chk("start_no_ack", {host_ack, tap_we}, 2'b00);
        step();
        start = 1'b0;
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            chk("clear_wr", {busy, dat_we, dat_waddr, dat_wdi}, {1'b1, 1'b1, AW'(i), 32'd0});
            if (hold) chk("hold_no_ack", {host_ack, tap_we}, 2'b00);
            step();
        end
        for (int j = 0; j < len; j++) begin
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                chk("wait_ready", {s_ready, dat_we}, 2'b10);
                exp_stall++;
                step();
            end
            s_valid = 1'b1;
            s_data  = samp[j];
            hist.push_front(samp[j]);
            @(negedge clk);
            chk("accept", {s_ready, dat_we, dat_waddr, dat_wdi}, {1'b1, 1'b1, AW'(j % NT), samp[j]});
            step();
            s_valid = 1'b0;
            s_data  = '0;
            for (int c = 0; c <= NT; c++) begin
                @(negedge clk);
                if (c < NT)
                    chk("issue_addr", {tap_re, dat_re, tap_raddr, dat_raddr},
                        {1'b1, 1'b1, AW'(c), AW'(((j - c) % NT + NT) % NT)});
                else
                    chk("drain_quiet", {tap_re, dat_re, s_ready}, 3'b000);
                if (c > 0) begin
                    k = c - 1;
                    exp_x = (k < hist.size()) ? hist[k] : '0;
                    chk("mac_flags", {mac_valid, mac_first, mac_last}, {1'b1, k == 0, k == NT - 1});
                    chk("mac_data", {mac_x, mac_h}, {exp_x, tap_model[k]});
                end else begin
                    chk("mac_idle", mac_valid, 1'b0);
                end
                chk("no_early_done", done, 1'b0);
                if (hold) chk("hold_no_ack", {host_ack, tap_we}, 2'b00);
                step();
            end
        end
        @(negedge clk);
        chk("done_pulse", {done, busy, s_ready}, 3'b110);
        step();
        @(negedge clk);
        chk("back_idle", {busy, done}, 2'b00);
        if (hold) begin
            chk("held_wr_ack", {host_ack, tap_we, tap_waddr, tap_wdi}, {1'b1, 1'b1, AW'(2), 32'h0BAD_0002});
            tap_model[2] = 32'h0BAD_0002;
        end
`ifdef FIR_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(exp_stall));
`else
        chk("stall_cnt_tied", stall_cnt, 32'd0);
`endif
        step();
        host_we = 1'b0;
    endtask

    initial begin
        host_vec_t v;
        rst = 1'b1; start = 1'b0; data_len = '0; s_valid = 1'b0; s_data = '0;
        host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < NT; i++) tap_model[i] = '0;
        step(); step();
        @(negedge clk);
        chk("reset_outs", {busy, done, s_ready, host_ack, tap_we, tap_re, dat_we, dat_re,
                           mac_valid, mac_first, mac_last, mac_x, stall_cnt},
            128'd0);
        step();
        rst = 1'b0;
        step();

        // Host op table: taps 1..11, out-of-range write, then read-backs.
        for (int i = 0; i < NT; i++) hv.push_back('{1'b1, AW'(i), 32'(i + 1), 32'd0, 1'b1});
        hv.push_back('{1'b1, AW'(12), 32'hDEAD_BEEF, 32'd0, 1'b0});
        hv.push_back('{1'b0, AW'(3),  32'd0, 32'd4,  1'b1});
        hv.push_back('{1'b0, AW'(12), 32'd0, 32'd0,  1'b0});
        hv.push_back('{1'b0, AW'(0),  32'd0, 32'd1,  1'b1});
        hv.push_back('{1'b0, AW'(10), 32'd0, 32'd11, 1'b1});
        hv.push_back('{1'b0, AW'(11), 32'd0, 32'd0,  1'b0});
        for (int i = 0; i < hv.size(); i++) host_op(hv[i]);

        // Two samples, 5 then 7.
        samp = '{32'd5, 32'd7};
        run(2, 1'b0);

        // Twelve samples: buffer wraps on the twelfth.
        samp.delete();
        for (int i = 0; i < 12; i++) samp.push_back(32'(100 + i));
        run(12, 1'b0);

        // Empty run goes straight from CLEAR to DONE.
        run(0, 1'b0);

        // Host write held through a run is served in the first IDLE cycle.
        samp = '{32'd3};
        run(1, 1'b1);
        host_op('{1'b0, AW'(2), 32'd0, 32'h0BAD_0002, 1'b1});

        // Reset in the middle of ISSUE.
        data_len = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < NT; i++) step();
        s_valid = 1'b1;
        s_data  = 32'd9;
        step();
        s_valid = 1'b0;
        s_data  = '0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_quiet", {tap_re, dat_re, s_ready, done, host_ack}, 5'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst", {busy, mac_valid, done}, 3'b000);
        for (int i = 0; i < 14; i++) begin
            step();
            @(negedge clk);
            chk("no_done_after_rst", {done, busy}, 2'b00);
        end
        step();
        samp = '{32'd21, 32'd22};
        run(2, 1'b0);

        // Randomised taps and runs.
        for (int i = 0; i < NT; i++) begin
            v = '{1'b1, AW'(i), $urandom, 32'd0, 1'b1};
            host_op(v);
        end
        for (int r = 0; r < 3; r++) begin
            int a;
            int len;
            a = $urandom_range(0, NT - 1);
            v = '{1'b0, AW'(a), 32'd0, tap_model[a], 1'b1};
            host_op(v);
            len = $urandom_range(1, 14);
            samp.delete();
            for (int i = 0; i < len; i++) samp.push_back($urandom);
            run(len, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_bram_seq.md
Name: fir_bram_seq

Overview:
- Sequencer and arbiter for the two 11-entry FIR block RAMs: the tap RAM (coefficients) and the data RAM (sample shift register, used as a circular buffer).
- Clears the data RAM on start, accepts one input sample at a time, and issues TAPS paired reads per sample to feed the MAC.
- Shares the tap RAM with a host (configuration) port; the host is served only while the sequencer is idle.

Parameters:
- ADDR_WIDTH, 12, BRAM address width.
- TAPS, 11, number of taps / RAM depth used.
- BIT_WIDTH, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; starts a run (ignored unless IDLE)
- data_len  in  32  samples per run, sampled on start
- s_valid  in  1  input sample valid
- s_data  in  BIT_WIDTH  input sample
- s_ready  out  1  sample accepted when s_valid&s_ready
- host_we, host_re  in  1 each  host tap write / read request, held until host_ack
- host_addr  in  ADDR_WIDTH  host tap index
- host_wdata  in  BIT_WIDTH  host write data
- host_rdata  out  BIT_WIDTH  host read data, valid with host_ack
- host_ack  out  1  one-cycle completion
- tap_we, tap_re  out  1 each  tap RAM strobes
- tap_waddr, tap_raddr  out  ADDR_WIDTH  tap RAM addresses
- tap_wdi  out  BIT_WIDTH  tap RAM write data
- tap_rdo  in  BIT_WIDTH  tap RAM read data (1-cycle registered)
- dat_we, dat_re  out  1 each  data RAM strobes
- dat_waddr, dat_raddr  out  ADDR_WIDTH  data RAM addresses
- dat_wdi  out  BIT_WIDTH  data RAM write data
- dat_rdo  in  BIT_WIDTH  data RAM read data
- mac_valid, mac_first, mac_last  out  1 each  MAC operand strobe / first product / last product
- mac_x, mac_h  out  BIT_WIDTH  = dat_rdo, tap_rdo
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- stall_cnt  out  32  see Optional Feature

Behaviour:
- Reset:
  - State goes to IDLE; wptr, k and count are 0.
  - Every strobe, address, data output, host_ack, done and mac_* output is 0.
  - Reset mid-run aborts the run with no done pulse.
- RAM read latency is 1 cycle. mac_valid, mac_first and mac_last are their issue-cycle flags delayed by 1 cycle, so they align with rdo.
- IDLE:
  - start=1 latches data_len, clears count, and goes to CLEAR. start has priority over host requests that cycle (no ack).
  - Otherwise a host request is served:
    - Write (host_we has priority over host_re): tap_we=1, tap_waddr=host_addr, tap_wdi=host_wdata, host_ack in the same cycle.
    - Read: tap_re=1, tap_raddr=host_addr; host_ack and host_rdata=tap_rdo 1 cycle later.
  - host_addr >= TAPS: no RAM strobe; ack is still given; read data is 0.
  - A read acked after leaving IDLE completes normally.
- CLEAR: writes 0 to data RAM addresses 0..TAPS-1, one per cycle (TAPS cycles). Then:
  - data_len=0 goes to DONE;
  - otherwise goes to WAIT_IN.
- WAIT_IN: s_ready=1. On handshake: dat_we=1, dat_waddr=wptr, dat_wdi=s_data; k=0; go to ISSUE.
- ISSUE, one read pair per cycle for k=0..TAPS-1:
  - tap_re=dat_re=1, tap_raddr=k, dat_raddr=(wptr-k) mod TAPS (wraps 0 -> TAPS-1).
  - k=0 flags first; k=TAPS-1 flags last. Then go to DRAIN.
- DRAIN (1 cycle): the last mac_valid/mac_last is emitted.
  - wptr advances (TAPS-1 wraps to 0); count increments.
  - count==data_len goes to DONE; otherwise goes to WAIT_IN.
- Per-sample cost: 1 accept + TAPS issue + 1 drain = 13 cycles at default TAPS.
- DONE: done=1 for 1 cycle, then IDLE. Host requests outside IDLE are not acked.
- s_ready is 0 in every state except WAIT_IN.

Optional Feature:
- Macro FIR_SEQ_STALL_CNT_EN.
- Defined: stall_cnt counts cycles in WAIT_IN with s_valid=0. It clears on an accepted start, saturates at 0xFFFFFFFF, and holds after DONE.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Host writes taps 1..11 to addresses 0..10, then reads address 3 -> host_ack 1 cycle after the request, host_rdata=4; a read of address 12 -> ack, host_rdata=0, no tap_re.
- start with data_len=2, sample 5 -> CLEAR writes 0 to addresses 0..10; then 11 mac_valid cycles with mac_x=5,0,...,0 and mac_h=1..11; mac_first on the 1st and mac_last on the 11th.
- Second sample 7 in the same run -> first pair mac_x=7, second pair mac_x=5, remaining 0; done pulses once; busy drops the next cycle.
- 12 samples with data_len=12 -> after wptr=10 the next write is to address 0; 12th sample's reads at dat_raddr 0,10,9,...,1.
- Host write pending during a run -> no host_ack and no tap_we until IDLE; ack in the first IDLE cycle.
- rst asserted mid-ISSUE -> next cycle busy=0, mac_valid=0, no done; a new start runs CLEAR from address 0.
